// File: rtl/arb_client_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_client_pkg
// Purpose  : Shared definitions for the arbiter request client: FSM state
//            encoding, wait-counter width and a saturating increment helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package arb_client_pkg;

  // Client FSM state encoding.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } client_state_e;

  localparam int unsigned WAIT_W = 16;
  localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
    return (v == WAIT_MAX) ? v : v + WAIT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with occupancy count. Read data is the head
//            entry, combinationally visible while the FIFO is non-empty.
// Ports    : clk, rst_n      - clock, async active-low reset
//            push_i, wdata_i - write strobe and data (ignored when full)
//            pop_i           - remove head entry (ignored when empty)
//            rdata_o         - head entry
//            count_o         - number of stored entries (0..DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [$clog2(DEPTH):0]  count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  do_push, do_pop;

  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i  && (count_q != '0);

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through valid entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/arb_req_client.sv
`default_nettype none
// ============================================================================
// Module   : arb_req_client
// Purpose  : Buffers upstream transactions and requests a round-robin
//            arbiter for each one; a granted entry is presented one cycle
//            later. Tracks request-to-grant wait, starvation and spurious
//            grants.
// Ports    : clk, rst_n                   - clock, async active-low reset
//            in_valid/in_ready/in_data    - upstream handshake and payload
//            req/grant                    - arbiter request / grant
//            out_valid/out_data           - granted payload (1-cycle pulse)
//            pending                      - buffered transaction count
//            max_wait                     - largest wait seen at a grant
//            starve_err/spur_err          - sticky error flags
//            err_clr                      - clears flags and max_wait
// Revision : 1.0 - initial release
// ============================================================================
module arb_req_client
  import arb_client_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    req,
  input  logic                    grant,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  pending,
  output logic [15:0]             max_wait,
  output logic                    starve_err,
  input  logic                    err_clr,
  output logic                    spur_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]         FULL_CNT    = (AW+1)'(DEPTH);
  localparam logic [AW:0]         ONE_CNT     = (AW+1)'(1);
  localparam logic [WAIT_W-1:0]   TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  client_state_e          state_q, state_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [WAIT_W-1:0]      max_wait_q, max_wait_d;
  logic                   starve_q, starve_d;
  logic                   spur_q, spur_d;
  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  logic [AW:0]            fifo_count;
  logic [DATA_WIDTH-1:0]  fifo_rdata;
  logic                   push, pop;

  // No bypass: a full buffer refuses input even if it pops this cycle.
  assign in_ready = (fifo_count != FULL_CNT);
  assign push     = in_valid && in_ready;
  // In REQ the buffer always holds at least one entry.
  assign req      = (state_q == REQ);
  assign pop      = req && grant;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_data),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    max_wait_d = max_wait_q;
    starve_d   = starve_q;
    spur_d     = spur_q;
    out_data_d = out_data_q;

    // Entering REQ on the push itself gives req the cycle after the push.
    case (state_q)
      IDLE: if ((fifo_count != '0) || push) state_d = REQ;
      REQ:  if (pop && (fifo_count == ONE_CNT) && !push) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // wait_q counts completed ungranted REQ cycles.
    if ((state_q == IDLE) || grant) begin
      wait_d = '0;
    end else begin
      wait_d = sat_inc(wait_q);
    end

    if (pop) begin
      out_data_d = fifo_rdata;
    end

    // err_clr wins over any same-cycle set or update.
    if (err_clr) begin
      max_wait_d = '0;
      starve_d   = 1'b0;
      spur_d     = 1'b0;
    end else begin
      if (pop && (wait_q > max_wait_q)) max_wait_d = wait_q;
      if (wait_d == TIMEOUT_CNT)        starve_d   = 1'b1;
      if (grant && !req)                spur_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_q      <= '0;
      max_wait_q  <= '0;
      starve_q    <= 1'b0;
      spur_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      max_wait_q  <= max_wait_d;
      starve_q    <= starve_d;
      spur_q      <= spur_d;
      out_valid_q <= pop;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign pending    = fifo_count;
  assign max_wait   = max_wait_q;
  assign starve_err = starve_q;
  assign spur_err   = spur_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_req_client.sv
`default_nettype none
// ============================================================================
// Module   : tb_arb_req_client
// Purpose  : Self-checking bench for arb_req_client (DEPTH 4, TIMEOUT 10).
//            Expected payloads are queued at stimulus time and compared by
//            an independent monitor whenever out_valid is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arb_req_client;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        req;
  logic        grant;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  pending;
  logic [15:0] max_wait;
  logic        starve_err;
  logic        spur_err;
  logic        err_clr;
  logic        gnt_en;
  logic        gnt_force;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Arbiter model: grants combinationally from req; gnt_force injects a
  // grant regardless of req.
  assign grant = gnt_force | (gnt_en & req);

  arb_req_client #(
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .TIMEOUT    (10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .req        (req),
    .grant      (grant),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .pending    (pending),
    .max_wait   (max_wait),
    .starve_err (starve_err),
    .err_clr    (err_clr),
    .spur_err   (spur_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(d);
    tick(1);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    err_clr = 1'b0; gnt_en = 1'b0; gnt_force = 1'b0;
    tick(3);

    // Reset values
    chk("rst_pending",    32'(pending),    32'd0);
    chk("rst_in_ready",   32'(in_ready),   32'd1);
    chk("rst_req",        32'(req),        32'd0);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_data",   out_data,        32'd0);
    chk("rst_max_wait",   32'(max_wait),   32'd0);
    chk("rst_starve",     32'(starve_err), 32'd0);
    chk("rst_spur",       32'(spur_err),   32'd0);
    rst_n = 1'b1;
    tick(1);

    // A,B,C with grant always available
    gnt_en = 1'b1;
    send(32'hA000_000A);
    chk("t1_req_after_push", 32'(req),     32'd1);
    chk("t1_pending1",       32'(pending), 32'd1);
    send(32'hB000_000B);
    chk("t1_pending_b",      32'(pending), 32'd1);
    send(32'hC000_000C);
    in_valid = 1'b0;
    tick(1);
    chk("t1_pending0",       32'(pending), 32'd0);
    chk("t1_req_fall",       32'(req),     32'd0);
    chk("t1_max_wait",       32'(max_wait), 32'd0);
    tick(1);
    chk("t1_out_valid_end",  32'(out_valid), 32'd0);

    // Fill to DEPTH, held push dropped until a slot frees
    gnt_en = 1'b0;
    send(32'hD0); send(32'hD1); send(32'hD2); send(32'hD3);
    chk("t2_pending_full",   32'(pending),  32'd4);
    chk("t2_in_ready_full",  32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = 32'hD4;
    tick(2);
    chk("t2_dropped",        32'(pending),  32'd4);
    gnt_en = 1'b1;
    tick(1);                         // pop D0, D4 not accepted (was full)
    chk("t2_after_pop",      32'(pending),  32'd3);
    chk("t2_in_ready_free",  32'(in_ready), 32'd1);
    chk("t2_max_wait",       32'(max_wait), 32'd5);
    gnt_en = 1'b0;
    exp_q.push_back(32'hD4);
    tick(1);                         // D4 accepted
    chk("t2_refill",         32'(pending),  32'd4);
    in_valid = 1'b0; gnt_en = 1'b1;
    tick(4);
    chk("t2_drained",        32'(pending),  32'd0);
    chk("t2_req_low",        32'(req),      32'd0);
    chk("t2_max_wait_keep",  32'(max_wait), 32'd5);
    gnt_en = 1'b0;
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t2_max_wait_clr",   32'(max_wait), 32'd0);

    // Starvation at TIMEOUT = 10, grant once wait count is 12
    send(32'h5555_AAAA);
    in_valid = 1'b0;
    tick(9);
    chk("t3_starve_before",  32'(starve_err), 32'd0);
    tick(1);
    chk("t3_starve_set",     32'(starve_err), 32'd1);
    chk("t3_req_unaffected", 32'(req),        32'd1);
    chk("t3_pending_kept",   32'(pending),    32'd1);
    tick(2);
    gnt_en = 1'b1;
    tick(1);
    chk("t3_max_wait",       32'(max_wait),   32'd12);
    chk("t3_popped",         32'(pending),    32'd0);
    chk("t3_starve_sticky",  32'(starve_err), 32'd1);
    gnt_en = 1'b0;
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t3_starve_clr",     32'(starve_err), 32'd0);

    // Spurious grant with empty buffer
    gnt_force = 1'b1; tick(1); gnt_force = 1'b0;
    chk("t4_spur_set",       32'(spur_err),  32'd1);
    chk("t4_no_out_valid",   32'(out_valid), 32'd0);
    chk("t4_pending0",       32'(pending),   32'd0);
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t4_spur_clr",       32'(spur_err),  32'd0);
    gnt_force = 1'b1; err_clr = 1'b1; tick(1);
    gnt_force = 1'b0; err_clr = 1'b0;
    chk("t4_clr_priority",   32'(spur_err),  32'd0);

    // Simultaneous push and pop at pending 2
    send(32'h1111_0000); send(32'h1111_0001);
    chk("t5_pending2",       32'(pending), 32'd2);
    gnt_en = 1'b1;
    send(32'h1111_0002);
    chk("t5_pending_same",   32'(pending), 32'd2);
    in_valid = 1'b0;
    tick(2);
    chk("t5_drained",        32'(pending), 32'd0);
    gnt_en = 1'b0;

    // Reset mid-burst with 3 pending
    send(32'h7700_0000); send(32'h7700_0001); send(32'h7700_0002); send(32'h7700_0003);
    in_valid = 1'b0; gnt_en = 1'b1;
    tick(1);
    gnt_en = 1'b0;
    tick(1);
    chk("t6_pending3",       32'(pending),  32'd3);
    chk("t6_out_data_hold",  out_data,      32'h7700_0000);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_pending",    32'(pending),   32'd0);
    chk("t6_rst_in_ready",   32'(in_ready),  32'd1);
    chk("t6_rst_req",        32'(req),       32'd0);
    chk("t6_rst_out_valid",  32'(out_valid), 32'd0);
    chk("t6_rst_out_data",   out_data,       32'd0);
    tick(2);
    rst_n = 1'b1; gnt_en = 1'b1;
    tick(5);
    chk("t6_post_pending",   32'(pending),   32'd0);
    chk("t6_post_req",       32'(req),       32'd0);
    gnt_en = 1'b0;
    tick(1);

    chk("scoreboard_empty",  32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/arb_req_client.md
ARB_REQ_CLIENT -- requirements
Module: arb_req_client

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the payload width in bits.
REQ-002 Parameter DEPTH, default 4, power of two >= 2, SHALL set the pending-transaction buffer depth.
REQ-003 Parameter TIMEOUT, default 255, range 1..65535, SHALL set the starvation threshold in cycles.
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream transaction valid.
REQ-007 in_ready  output  1  block can accept a transaction.
REQ-008 in_data  input  DATA_WIDTH  upstream payload.
REQ-009 req  output  1  request to the round-robin arbiter.
REQ-010 grant  input  1  this client's grant bit from the arbiter, combinational from req.
REQ-011 out_valid  output  1  one-cycle pulse: granted payload on out_data.
REQ-012 out_data  output  DATA_WIDTH  granted payload.
REQ-013 pending  output  $clog2(DEPTH)+1  number of buffered transactions.
REQ-014 max_wait  output  16  largest request-to-grant wait seen, in cycles.
REQ-015 starve_err  output  1  sticky: wait reached TIMEOUT.
REQ-016 spur_err  output  1  sticky: grant seen while req low.
REQ-017 err_clr  input  1  synchronous clear of starve_err, spur_err and max_wait.

Function
REQ-018 Push SHALL occur when in_valid && in_ready; in_ready SHALL equal (pending != DEPTH), with no bypass while full even if a pop occurs that cycle.
REQ-019 FSM SHALL have states IDLE and REQ; IDLE->REQ when pending != 0; REQ->IDLE when a pop leaves pending == 0 and no push occurs that cycle; otherwise it SHALL remain in REQ.
REQ-020 req SHALL be 1 exactly in state REQ, driven from registered state only; first req SHALL appear the cycle after the first push into an empty buffer.
REQ-021 A cycle with req && grant SHALL pop the oldest entry (FIFO order); out_valid SHALL be 1 and out_data SHALL equal that entry in the following cycle (latency 1).
REQ-022 out_data SHALL hold its last value while out_valid is 0.
REQ-023 Simultaneous push and pop SHALL leave pending unchanged and preserve order.
REQ-024 Back-to-back grants SHALL pop one entry per cycle with no bubble while pending > 0.
REQ-025 wait counter (16 bits) SHALL clear on any grant or in IDLE, increment each REQ cycle without grant, and saturate at 65535.
REQ-026 On a grant, max_wait SHALL update to the wait count if it exceeds max_wait.
REQ-027 starve_err SHALL set on the cycle the wait count reaches TIMEOUT; it SHALL NOT alter req or FIFO behaviour.
REQ-028 spur_err SHALL set on any cycle with grant && !req; no pop SHALL occur.
REQ-029 err_clr SHALL take priority over a same-cycle set of any error flag and over a same-cycle max_wait update.

Reset
REQ-030 Reset SHALL force state IDLE, pending 0, in_ready 1, req 0, out_valid 0, out_data 0, wait count 0, max_wait 0, starve_err 0, spur_err 0.
REQ-031 Reset mid-operation SHALL discard all buffered transactions with no out_valid pulse after deassertion.

Structure
REQ-032 The FSM state enum (IDLE, REQ) SHALL live in shared package arb_client_pkg.
REQ-033 Buffering SHALL be a sub-module sync_fifo (DEPTH, DATA_WIDTH, count output); FSM, counters and flags SHALL be in arb_req_client.

Verification
REQ-034 Reset, push A,B,C, grant tied 1 -> req rises cycle after first push; out_data A,B,C on consecutive cycles; pending back to 0; req falls.
REQ-035 Push DEPTH=4 entries, grant 0 -> in_ready 0 with pending 4; push with in_valid held dropped until a grant frees a slot.
REQ-036 TIMEOUT=10, hold grant 0 with one entry -> starve_err sets on 10th REQ cycle; grant at cycle 12 -> max_wait 12, pop occurs.
REQ-037 grant pulsed with empty buffer -> spur_err 1, out_valid stays 0, pending 0; err_clr -> spur_err 0.
REQ-038 Simultaneous push and grant at pending 2 -> pending stays 2, output order unchanged.
REQ-039 Assert rst_n low with 3 pending mid-burst -> all outputs at reset values, no out_valid after release.
